// File: rtl/conv_patch_collector.sv
// ---------------------------------------------------------------------------
// conv_patch_collector
//
// Column-stream patch assembler. Accepts one image column per beat into a
// MAX_P-deep sliding window and, when the convolution enable strobe lands on
// an accepted beat, captures the newest patch_size columns as a patch. Each
// patch is presented downstream on a valid/ready interface with its x
// position inside the row. Backpressure from the patch output stalls the
// column input, so an accepted strobe is never lost.
//
// Optional feature macro: CONV_PATCH_CHECK_EN
//   defined   : a strobe that arrives before patch_size columns of the row
//               have been seen sets err_underfill (sticky) and emits no patch.
//   undefined : err_underfill reads 0 and every accepted strobe captures;
//               columns not yet received read as 0.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   patch_size     active patch width 1..MAX_P (0 behaves as 1)
//   col_valid/col_ready/col_data/col_last   column input stream
//   conv_enable    capture strobe, qualified by an accepted beat
//   patch_valid/patch_ready                 patch output handshake
//   patch_data     slot k at [k*IMG_H +: IMG_H], slot 0 = newest column
//   patch_x        0-based patch index within the row (5 bits, wraps)
//   patch_last     patch was captured on the row's last column
//   err_underfill  sticky underfill flag
// ---------------------------------------------------------------------------
module conv_patch_collector #(
    parameter int IMG_H = 28,
    parameter int MAX_P = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               patch_size,
    input  logic                     col_valid,
    output logic                     col_ready,
    input  logic [IMG_H-1:0]         col_data,
    input  logic                     col_last,
    input  logic                     conv_enable,
    output logic                     patch_valid,
    input  logic                     patch_ready,
    output logic [MAX_P*IMG_H-1:0]   patch_data,
    output logic [4:0]               patch_x,
    output logic                     patch_last,
    output logic                     err_underfill
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [IMG_H-1:0]         win_q [MAX_P];
    logic [IMG_H-1:0]         win_d [MAX_P];
    logic [IMG_H-1:0]         win_shift [MAX_P];
    logic [2:0]               fill_q, fill_d;
    logic [4:0]               x_q, x_d;
    logic [MAX_P*IMG_H-1:0]   pdata_q, pdata_d;
    logic [4:0]               px_q, px_d;
    logic                     plast_q, plast_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     capture;
    logic                     underfill;
    logic [3:0]               ps_eff;
    logic [MAX_P*IMG_H-1:0]   cap_data;

    // Output side: EMPTY always accepts a column; FULL only when the held
    // patch leaves this cycle, which frees the register for a new capture.
    assign patch_valid   = (state_q == S_FULL);
    assign col_ready     = !patch_valid || patch_ready;
    assign accept        = col_valid && col_ready;

    assign patch_data    = pdata_q;
    assign patch_x       = px_q;
    assign patch_last    = plast_q;
    assign err_underfill = err_q;

    // Effective width: 0 behaves as 1, and never wider than the window.
    always_comb begin
        ps_eff = {1'b0, patch_size};
        if (patch_size == 3'd0) begin
            ps_eff = 4'd1;
        end else if ({1'b0, patch_size} > 4'(MAX_P)) begin
            ps_eff = 4'(MAX_P);
        end
    end

`ifdef CONV_PATCH_CHECK_EN
    logic [3:0] fill_inc;
    logic       enough;

    // fill_q counts columns before this beat; the beat itself adds one.
    assign fill_inc  = {1'b0, fill_q} + 4'd1;
    assign enough    = (fill_inc >= ps_eff);
    assign capture   = accept && conv_enable && enough;
    assign underfill = accept && conv_enable && !enough;
`else
    assign capture   = accept && conv_enable;
    assign underfill = 1'b0;
`endif

    // Post-shift window and the masked patch built from it. Slots at or
    // beyond the active width are forced to zero in the captured patch.
    generate
        for (genvar gi = 0; gi < MAX_P; gi++) begin : g_slot
            localparam logic [3:0] SLOT_IDX = 4'(gi);
            if (gi == 0) begin : g_head
                assign win_shift[gi] = col_data;
            end else begin : g_tail
                assign win_shift[gi] = win_q[gi-1];
            end
            assign cap_data[gi*IMG_H +: IMG_H] =
                (SLOT_IDX < ps_eff) ? win_shift[gi] : '0;
        end
    endgenerate

    // Row state: window, fill count, x counter, sticky error. A row-end
    // beat clears the row state after its own capture has used it.
    always_comb begin
        for (int k = 0; k < MAX_P; k++) begin
            win_d[k] = win_q[k];
        end
        fill_d = fill_q;
        x_d    = x_q;
        err_d  = err_q | underfill;

        if (accept) begin
            if (col_last) begin
                for (int k = 0; k < MAX_P; k++) begin
                    win_d[k] = '0;
                end
                fill_d = 3'd0;
                x_d    = 5'd0;
            end else begin
                for (int k = 0; k < MAX_P; k++) begin
                    win_d[k] = win_shift[k];
                end
                fill_d = (fill_q == 3'(MAX_P)) ? fill_q : fill_q + 3'd1;
                if (capture) begin
                    x_d = x_q + 5'd1;
                end
            end
        end
    end

    // Output register FSM. A capture while FULL can only happen when
    // patch_ready is high (col_ready gates it), so the old patch is consumed
    // and replaced in the same cycle with no bubble.
    always_comb begin
        state_d = state_q;
        pdata_d = pdata_q;
        px_d    = px_q;
        plast_d = plast_q;

        case (state_q)
            S_EMPTY: begin
                if (capture) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (!capture && patch_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (capture) begin
            pdata_d = cap_data;
            px_d    = x_q;
            plast_d = col_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            for (int k = 0; k < MAX_P; k++) begin
                win_q[k] <= '0;
            end
            fill_q  <= 3'd0;
            x_q     <= 5'd0;
            pdata_q <= '0;
            px_q    <= 5'd0;
            plast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < MAX_P; k++) begin
                win_q[k] <= win_d[k];
            end
            fill_q  <= fill_d;
            x_q     <= x_d;
            pdata_q <= pdata_d;
            px_q    <= px_d;
            plast_q <= plast_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_conv_patch_collector.sv
// ---------------------------------------------------------------------------
// Self-checking bench for conv_patch_collector. A driver issues column beats
// and feeds each accepted beat to a row-history reference model, which queues
// the patch it expects; a monitor pops and compares whenever a patch is
// handed off downstream.
// ---------------------------------------------------------------------------
module tb_conv_patch_collector;

    localparam int IMG_H = 28;
    localparam int MAX_P = 7;
    localparam int PW    = MAX_P * IMG_H;

    logic             clk;
    logic             rst;
    logic [2:0]       patch_size;
    logic             col_valid;
    logic             col_ready;
    logic [IMG_H-1:0] col_data;
    logic             col_last;
    logic             conv_enable;
    logic             patch_valid;
    logic             patch_ready;
    logic [PW-1:0]    patch_data;
    logic [4:0]       patch_x;
    logic             patch_last;
    logic             err_underfill;

    conv_patch_collector #(.IMG_H(IMG_H), .MAX_P(MAX_P)) dut (
        .clk          (clk),
        .rst          (rst),
        .patch_size   (patch_size),
        .col_valid    (col_valid),
        .col_ready    (col_ready),
        .col_data     (col_data),
        .col_last     (col_last),
        .conv_enable  (conv_enable),
        .patch_valid  (patch_valid),
        .patch_ready  (patch_ready),
        .patch_data   (patch_data),
        .patch_x      (patch_x),
        .patch_last   (patch_last),
        .err_underfill(err_underfill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] data;
        logic [4:0]    x;
        logic          last;
    } exp_t;

    exp_t             sb[$];
    logic [IMG_H-1:0] row_cols[$];   // accepted columns of this row, newest first
    int               mx;
    bit               exp_err;
    int               rdy_mode;      // 0 random, 1 always ready, 2 stalled
    bit               nb_check;
    bit               nb_armed;
    int               n_tests;
    int               n_fail;

    task automatic check(input string name, input logic [PW-1:0] act,
                         input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a patch is the newest ps columns of the row so far.
    function automatic void model_beat(input logic [IMG_H-1:0] d, input bit en,
                                       input bit last, input int ps_in);
        int   ps;
        bit   emit;
        exp_t e;
        ps = (ps_in == 0) ? 1 : ps_in;
        row_cols.push_front(d);
        if (row_cols.size() > MAX_P) void'(row_cols.pop_back());
        if (en) begin
            emit = 1'b1;
`ifdef CONV_PATCH_CHECK_EN
            if (row_cols.size() < ps) begin
                emit    = 1'b0;
                exp_err = 1'b1;
            end
`endif
            if (emit) begin
                e.data = '0;
                for (int k = 0; k < MAX_P; k++) begin
                    if (k < ps && k < row_cols.size())
                        e.data[k*IMG_H +: IMG_H] = row_cols[k];
                end
                e.x    = 5'(mx);
                e.last = last;
                sb.push_back(e);
                mx = (mx + 1) % 32;
            end
        end
        if (last) begin
            row_cols.delete();
            mx = 0;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_col(input logic [IMG_H-1:0] d, input bit en, input bit last);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        col_valid = 1'b1; col_data = d; conv_enable = en; col_last = last;
        while (!done) begin
            #1;
            if (nb_check && nb_armed) check("no_bubble_valid", PW'(patch_valid), PW'(1'b1));
            if (col_ready) begin
                model_beat(d, en, last, int'(patch_size));
                if (en) nb_armed = 1'b1;
                done = 1'b1;
            end else if (waited >= 200) begin
                check("col_ready_timeout", PW'(col_ready), PW'(1'b1));
                done = 1'b1;
            end
            @(negedge clk);
            waited++;
        end
        col_valid = 1'b0; conv_enable = 1'b0; col_last = 1'b0;
    endtask

    task automatic set_rdy(input int m);
        #1;
        rdy_mode = m;
        @(negedge clk);
    endtask

    function automatic logic [IMG_H-1:0] rnd_col();
        return IMG_H'($urandom);
    endfunction

    // Monitor: drives patch_ready at each falling edge, then compares any
    // patch that will be handed off at the next rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       patch_ready = 1'($urandom_range(0, 1));
                1:       patch_ready = 1'b1;
                default: patch_ready = 1'b0;
            endcase
            #2;
            if (!rst && patch_valid && patch_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_patch: got x=%0d with no patch expected", patch_x);
                end else begin
                    e = sb.pop_front();
                    check("patch_data", patch_data, e.data);
                    check("patch_x", PW'(patch_x), PW'(e.x));
                    check("patch_last", PW'(patch_last), PW'(e.last));
                end
            end
        end
    end

    initial begin : main
        bit row_start;
        int waited;
        n_tests = 0; n_fail = 0; mx = 0; exp_err = 1'b0;
        nb_check = 1'b0; nb_armed = 1'b0; rdy_mode = 2;
        rst = 1'b1; col_valid = 1'b0; col_data = '0; col_last = 1'b0;
        conv_enable = 1'b0; patch_ready = 1'b0; patch_size = 3'd3;

        // Reset values (patch_ready held low so col_ready must come from !patch_valid).
        repeat (2) @(negedge clk);
        #1;
        check("rst_col_ready", PW'(col_ready), PW'(1'b1));
        check("rst_patch_valid", PW'(patch_valid), PW'(1'b0));
        check("rst_patch_data", patch_data, '0);
        check("rst_patch_x", PW'(patch_x), '0);
        check("rst_patch_last", PW'(patch_last), '0);
        check("rst_err", PW'(err_underfill), '0);
        rdy_mode = 1;
        @(negedge clk);
        rst = 1'b0;

        // Strobes on beats 3,4,5 with data = beat index.
        patch_size = 3'd3;
        for (int i = 1; i <= 5; i++) send_col(IMG_H'(i), i >= 3, 1'b0);
        send_col(rnd_col(), 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Row-end capture followed by a strobe on the first beat of a new row.
        for (int i = 1; i <= 4; i++) send_col(rnd_col(), i == 4, i == 4);
        send_col(rnd_col(), 1'b1, 1'b0);
        send_col(rnd_col(), 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("err_after_row_end", PW'(err_underfill), PW'(exp_err));

        // Backpressure: hold the first patch and offer beats that must stall.
        set_rdy(2);
        for (int i = 1; i <= 3; i++) send_col(rnd_col(), i == 3, 1'b0);
        col_valid = 1'b1; col_data = rnd_col(); conv_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_col_ready", PW'(col_ready), '0);
            if (sb.size() > 0) check("bp_data_frozen", patch_data, sb[0].data);
            else check("bp_pending_patch", PW'(sb.size()), PW'(1));
            @(negedge clk);
        end
        col_valid = 1'b0; conv_enable = 1'b0;
        set_rdy(1);
        for (int i = 0; i < 4; i++) send_col(rnd_col(), 1'b1, 1'b0);
        send_col(rnd_col(), 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // 40 captures in one row, width 1: x wraps after 31; no bubbles.
        patch_size = 3'd1;
        nb_check = 1'b1; nb_armed = 1'b0;
        for (int i = 0; i < 40; i++) send_col(rnd_col(), 1'b1, i == 39);
        nb_check = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while a patch is pending mid-row.
        patch_size = 3'd3;
        set_rdy(2);
        for (int i = 1; i <= 3; i++) send_col(rnd_col(), i == 3, 1'b0);
        rst = 1'b1;
        sb.delete(); row_cols.delete(); mx = 0; exp_err = 1'b0;
        #1;
        check("midrst_patch_valid", PW'(patch_valid), '0);
        check("midrst_err", PW'(err_underfill), '0);
        @(negedge clk);
        rst = 1'b0;
        set_rdy(1);
        for (int i = 1; i <= 3; i++) send_col(rnd_col(), i == 3, 1'b0);
        send_col(rnd_col(), 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Random traffic with random backpressure and widths.
        set_rdy(0);
        row_start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit last;
            if (row_start) patch_size = 3'($urandom_range(0, 7));
            last = ($urandom_range(0, 9) == 0);
            send_col(rnd_col(), $urandom_range(0, 2) != 0, last);
            row_start = last;
        end
        send_col(rnd_col(), 1'b0, 1'b1);
        set_rdy(1);
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drained", PW'(sb.size()), '0);
        check("err_final", PW'(err_underfill), PW'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
